// File: rtl/router_wrap_olck_arbiter.sv
// rtl/router_wrap_olck_arbiter.sv - round-robin output-lock arbiter with stall watchdog
module router_wrap_olck_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int OWNER_W = $clog2(NUM_REQ),
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_head,
  input  logic [NUM_REQ-1:0] req_tail,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] grant,
  output logic               locked,
  output logic [OWNER_W-1:0] owner_id,
  output logic               xfer,
  output logic               timeout
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  localparam logic [TO_W-1:0]    WDOG_MAX  = '1;
  localparam logic [TO_W-1:0]    TIMEOUT_V = TO_W'(TIMEOUT);
  localparam logic [OWNER_W-1:0] LAST_REQ  = OWNER_W'(NUM_REQ - 1);

  state_t               state_q, state_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [OWNER_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [TO_W-1:0]      wdog_q, wdog_d;
  logic                 timeout_q, timeout_d;

  logic [NUM_REQ-1:0]   cand;
  logic [OWNER_W-1:0]   pick;
  logic                 pick_found;
  logic                 own_valid;
  logic                 own_tail;
  logic                 wdog_hit;

  // Only head flits compete; body flits never open a new lock.
  assign cand      = req_valid & req_head;
  assign own_valid = req_valid[owner_q];
  assign own_tail  = req_tail[owner_q];
  assign xfer      = (state_q == ST_LOCK) & own_valid & out_ready;
  assign wdog_hit  = (TIMEOUT != 0) && (wdog_q == TIMEOUT_V);

  // Round-robin pick: scan from the requester just after the last owner.
  always_comb begin
    int idx;
    pick       = '0;
    pick_found = 1'b0;
    idx        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!pick_found && cand[idx[OWNER_W-1:0]]) begin
        pick_found = 1'b1;
        pick       = idx[OWNER_W-1:0];
      end
    end
  end

  // Lock FSM next state: acquire on a head, release on tail transfer or watchdog expiry.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    wdog_d    = wdog_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_LOCK;
          owner_d = pick;
          grant_d = NUM_REQ'(1) << pick;
          wdog_d  = '0;
        end
      end
      ST_LOCK: begin
        if (xfer && own_tail) begin
          // Normal release wins even if the watchdog is at its limit this cycle.
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = owner_q;
        end else if (xfer) begin
          wdog_d = '0;
        end else if (wdog_hit) begin
          state_d   = ST_IDLE;
          grant_d   = '0;
          rr_ptr_d  = owner_q;
          timeout_d = 1'b1;
        end else if (wdog_q != WDOG_MAX) begin
          wdog_d = wdog_q + TO_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers; reset leaves the pointer at the last requester so requester 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= LAST_REQ;
      grant_q   <= '0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant    = grant_q;
  assign locked   = (state_q == ST_LOCK);
  assign owner_id = owner_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_router_wrap_olck_arbiter.sv
// tb/tb_router_wrap_olck_arbiter.sv - self-checking bench for the output-lock arbiter
module tb_router_wrap_olck_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] v, h, t;
  logic       rdy;

  logic [3:0] g_a, g_b;
  logic       l_a, l_b;
  logic [1:0] o_a, o_b;
  logic       x_a, x_b;
  logic       to_a, to_b;

  always #5 clk = ~clk;

  router_wrap_olck_arbiter #(.NUM_REQ(4), .TIMEOUT(5), .TO_W(8)) dut_a (
    .clk(clk), .reset(reset), .req_valid(v), .req_head(h), .req_tail(t),
    .out_ready(rdy), .grant(g_a), .locked(l_a), .owner_id(o_a), .xfer(x_a),
    .timeout(to_a)
  );

  router_wrap_olck_arbiter #(.NUM_REQ(4), .TIMEOUT(0), .TO_W(8)) dut_b (
    .clk(clk), .reset(reset), .req_valid(v), .req_head(h), .req_tail(t),
    .out_ready(rdy), .grant(g_b), .locked(l_b), .owner_id(o_b), .xfer(x_b),
    .timeout(to_b)
  );

  typedef struct {
    bit lk;
    int own;
    int rr;
    int wd;
    bit tp;
  } mdl_t;

  mdl_t ma, mb;
  int   checks = 0;
  int   errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.lk = 0; m.own = 0; m.rr = 3; m.wd = 0; m.tp = 0;
    return m;
  endfunction

  function automatic bit bit_of(input logic [3:0] vec, input int i);
    int vi;
    vi = int'(vec);
    return ((vi >> i) & 1) != 0;
  endfunction

  function automatic bit mdl_xfer(input mdl_t m);
    return m.lk && bit_of(v, m.own) && rdy;
  endfunction

  // One clock of the arbiter as described: pick in IDLE, release/stall rules in LOCK.
  function automatic mdl_t mdl_step(input mdl_t m, input int tmo);
    mdl_t n;
    bit   x;
    n    = m;
    n.tp = 0;
    if (!m.lk) begin
      for (int k = 1; k <= 4; k++) begin
        int i;
        i = (m.rr + k) % 4;
        if (bit_of(v, i) && bit_of(h, i)) begin
          n.lk = 1; n.own = i; n.wd = 0;
          break;
        end
      end
    end else begin
      x = mdl_xfer(m);
      if (x && bit_of(t, m.own)) begin
        n.lk = 0; n.rr = m.own;
      end else if (x) begin
        n.wd = 0;
      end else if (tmo != 0 && m.wd == tmo) begin
        n.lk = 0; n.rr = m.own; n.tp = 1;
      end else if (m.wd < 255) begin
        n.wd = m.wd + 1;
      end
    end
    return n;
  endfunction

  function automatic int grant_of(input mdl_t m);
    return m.lk ? (1 << m.own) : 0;
  endfunction

  task automatic check_outs();
    check_val("a_grant",   g_a,  grant_of(ma));
    check_val("a_locked",  l_a,  ma.lk);
    check_val("a_owner",   o_a,  ma.own);
    check_val("a_timeout", to_a, ma.tp);
    check_val("b_grant",   g_b,  grant_of(mb));
    check_val("b_locked",  l_b,  mb.lk);
    check_val("b_owner",   o_b,  mb.own);
    check_val("b_timeout", to_b, mb.tp);
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cyc();
    #3;
    check_val("a_xfer", x_a, mdl_xfer(ma));
    check_val("b_xfer", x_b, mdl_xfer(mb));
    ma = mdl_step(ma, 5);
    mb = mdl_step(mb, 0);
    @(posedge clk);
    #1;
    check_outs();
  endtask

  // Asynchronous reset pulse mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #3;
    reset = 1'b0;
    ma = mdl_reset();
    mb = mdl_reset();
    #1;
    check_outs();
    check_val("rst_xfer", x_a, 0);
    @(posedge clk);
    #1;
    check_outs();
    reset = 1'b1;
  endtask

  task automatic set_in(input logic [3:0] vv, input logic [3:0] hh, input logic [3:0] tt, input logic rr);
    v = vv; h = hh; t = tt; rdy = rr;
  endtask

  initial begin
    int          got[$];
    int          exp_seq[5];
    int          pulses;
    logic [3:0]  rdy_pat;

    exp_seq = '{0, 1, 2, 3, 0};
    reset   = 1'b0;
    set_in(4'h0, 4'h0, 4'h0, 1'b0);
    ma = mdl_reset();
    mb = mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs();
    reset = 1'b1;

    // Single-flit packet from requester 0.
    set_in(4'b0001, 4'b0001, 4'b0001, 1'b1);
    cyc();
    check_val("s1_grant", g_a, 4'b0001);
    set_in(4'b0001, 4'b0001, 4'b0001, 1'b1);
    cyc();
    check_val("s1_release", g_a, 4'b0000);
    set_in(4'h0, 4'h0, 4'h0, 1'b1);
    cyc();

    // Everyone streams single-flit packets: round-robin with one bubble between grants.
    do_reset();
    set_in(4'hF, 4'hF, 4'hF, 1'b1);
    for (int c = 0; c < 9; c++) begin
      cyc();
      for (int i = 0; i < 4; i++)
        if (bit_of(g_a, i)) got.push_back(i);
    end
    check_val("rr_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      check_val("rr_order", got[i], exp_seq[i]);

    // Multi-flit packet from 2 with a stall while 1 waits.
    do_reset();
    set_in(4'b0100, 4'b0100, 4'b0000, 1'b1);
    cyc();
    rdy_pat = 4'b0011;
    for (int s = 0; s < 7; s++) begin
      set_in(4'b0110, (s == 3) ? 4'b0110 : 4'b0010, (s == 6) ? 4'b0100 : 4'b0000,
             !(s == 2 || s == 3));
      cyc();
      if (s < 6) check_val("s3_hold", g_a, 4'b0100);
    end
    check_val("s3_bubble", g_a, 4'b0000);
    set_in(4'b0010, 4'b0010, 4'b0000, 1'b1);
    cyc();
    check_val("s3_next", g_a, 4'b0010);

    // Owner 1 goes silent: watchdog forces one release.
    do_reset();
    set_in(4'b0010, 4'b0010, 4'b0000, 1'b1);
    cyc();
    set_in(4'b0010, 4'b0000, 4'b0000, 1'b1);
    cyc();
    set_in(4'h0, 4'h0, 4'h0, 1'b1);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (to_a) pulses++;
      if (to_b) pulses += 100;
    end
    check_val("s4_pulses", pulses, 1);
    check_val("s4_locked", l_a, 0);

    // Head-less flit never locks; reset during a packet; requester 0 wins afterwards.
    do_reset();
    set_in(4'b1000, 4'b0000, 4'b0000, 1'b1);
    repeat (3) cyc();
    check_val("s5_nohead", g_a, 4'b0000);
    set_in(4'b1000, 4'b1000, 4'b0000, 1'b1);
    cyc();
    check_val("s5_lock3", g_a, 4'b1000);
    do_reset();
    set_in(4'b1001, 4'b1001, 4'b0000, 1'b1);
    cyc();
    check_val("s5_after_rst", g_a, 4'b0001);

    // Tail transfer in the cycle the watchdog hits its limit: normal release.
    do_reset();
    set_in(4'b0001, 4'b0001, 4'b0000, 1'b0);
    cyc();
    repeat (5) cyc();
    set_in(4'b0001, 4'b0000, 4'b0001, 1'b1);
    cyc();
    check_val("s6_timeout", to_a, 0);
    check_val("s6_locked", l_a, 0);
    set_in(4'h0, 4'h0, 4'h0, 1'b1);
    cyc();

    // Random traffic against the model, with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        set_in(4'($urandom), 4'($urandom), 4'($urandom & $urandom), $urandom_range(0, 4) != 0);
        cyc();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
